// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Four-state instruction sequencer that drives the register
//                file, ALU and write-back mux. It accepts one instruction
//                over a valid/ready handshake, decodes it, and reports
//                retirement, illegal encodings and a retired-instruction
//                count.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InstrValid,
    input  logic [31:0] Instr,
    output logic        InstrReady,
    output logic [4:0]  RR1,
    output logic [4:0]  RR2,
    output logic [4:0]  WR,
    output logic        WE,
    output logic [31:0] WD,
    output logic        MuxCtrl,
    output logic [3:0]  Op,
    output logic [4:0]  ShiftCount,
    output logic        Done,
    output logic        Illegal,
    output logic [15:0] RetireCount
);

    localparam logic [5:0] c_OPC_RTYPE = 6'h00;
    localparam logic [5:0] c_OPC_LI    = 6'h0F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  rr1_q, rr1_d;
    logic [4:0]  rr2_q, rr2_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wd_q, wd_d;
    logic        mux_q, mux_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  sh_q, sh_d;
    logic [15:0] retire_q, retire_d;

    // Instruction fields
    logic [5:0]  opc_w;
    logic [4:0]  rs_w, rt_w, rd_w, shamt_w;
    logic [5:0]  funct_w;
    logic [15:0] imm_w;

    assign opc_w   = Instr[31:26];
    assign rs_w    = Instr[25:21];
    assign rt_w    = Instr[20:16];
    assign rd_w    = Instr[15:11];
    assign shamt_w = Instr[10:6];
    assign funct_w = Instr[5:0];
    assign imm_w   = Instr[15:0];

    // Decoded datapath settings for the word on Instr
    logic        dec_legal;
    logic [4:0]  dec_rr1, dec_rr2, dec_wr, dec_sh;
    logic [3:0]  dec_op;
    logic        dec_mux;
    logic [31:0] dec_wd;

    // Decode the incoming word so it can be captured on the accept edge,
    // making every datapath output already registered during DECODE.
    always_comb begin
        dec_legal = 1'b0;
        dec_rr1   = rs_w;
        dec_rr2   = rt_w;
        dec_wr    = rd_w;
        dec_op    = 4'd0;
        dec_sh    = shamt_w;
        dec_mux   = 1'b1;
        dec_wd    = 32'd0;
        case (opc_w)
            c_OPC_RTYPE: begin
                dec_legal = 1'b1;
                case (funct_w)
                    6'h20: dec_op = 4'd0;
                    6'h22: dec_op = 4'd1;
                    6'h24: dec_op = 4'd2;
                    6'h25: dec_op = 4'd3;
                    // Shifts route rt to both read ports so ALU input A
                    // carries the operand being shifted.
                    6'h00: begin dec_op = 4'd4; dec_rr1 = rt_w; end
                    6'h02: begin dec_op = 4'd5; dec_rr1 = rt_w; end
                    6'h03: begin dec_op = 4'd6; dec_rr1 = rt_w; end
                    6'h2B: dec_op = 4'd7;
                    6'h2A: dec_op = 4'd8;
                    default: dec_legal = 1'b0;
                endcase
            end
            c_OPC_LI: begin
                dec_legal = 1'b1;
                dec_rr1   = rt_w;
                dec_rr2   = rt_w;
                dec_wr    = rt_w;
                dec_op    = 4'd0;
                dec_sh    = 5'd0;
                dec_mux   = 1'b0;
                dec_wd    = {{16{imm_w[15]}}, imm_w};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and next-output logic; datapath fields hold unless loaded.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        we_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        rr1_d     = rr1_q;
        rr2_d     = rr2_q;
        wr_d      = wr_q;
        wd_d      = wd_q;
        mux_d     = mux_q;
        op_d      = op_q;
        sh_d      = sh_q;
        retire_d  = retire_q;
        case (state_q)
            S_IDLE: begin
                if (InstrValid) begin
                    state_d = S_DECODE;
                    if (dec_legal) begin
                        rr1_d = dec_rr1;
                        rr2_d = dec_rr2;
                        wr_d  = dec_wr;
                        wd_d  = dec_wd;
                        mux_d = dec_mux;
                        op_d  = dec_op;
                        sh_d  = dec_sh;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (illegal_q) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                we_d    = 1'b1;
                done_d  = 1'b1;
            end
            S_WB: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                retire_d = retire_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any instruction in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            rr1_q     <= 5'd0;
            rr2_q     <= 5'd0;
            wr_q      <= 5'd0;
            wd_q      <= 32'd0;
            mux_q     <= 1'b0;
            op_q      <= 4'd0;
            sh_q      <= 5'd0;
            retire_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            rr1_q     <= rr1_d;
            rr2_q     <= rr2_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
            mux_q     <= mux_d;
            op_q      <= op_d;
            sh_q      <= sh_d;
            retire_q  <= retire_d;
        end
    end

    assign InstrReady  = ready_q;
    assign WE          = we_q;
    assign Done        = done_q;
    assign Illegal     = illegal_q;
    assign RR1         = rr1_q;
    assign RR2         = rr2_q;
    assign WR          = wr_q;
    assign WD          = wd_q;
    assign MuxCtrl     = mux_q;
    assign Op          = op_q;
    assign ShiftCount  = sh_q;
    assign RetireCount = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer with an attached
//                register-file/ALU model and an instruction-level reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        InstrReady;
    logic [4:0]  RR1, RR2, WR;
    logic        WE;
    logic [31:0] WD;
    logic        MuxCtrl;
    logic [3:0]  Op;
    logic [4:0]  ShiftCount;
    logic        Done;
    logic        Illegal;
    logic [15:0] RetireCount;

    instr_sequencer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InstrValid (InstrValid),
        .Instr      (Instr),
        .InstrReady (InstrReady),
        .RR1        (RR1),
        .RR2        (RR2),
        .WR         (WR),
        .WE         (WE),
        .WD         (WD),
        .MuxCtrl    (MuxCtrl),
        .Op         (Op),
        .ShiftCount (ShiftCount),
        .Done       (Done),
        .Illegal    (Illegal),
        .RetireCount(RetireCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        legal;
        logic [4:0]  rr1, rr2, wr;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic        mux;
        logic [31:0] wd;
        logic [31:0] result;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [15:0] exp_retire = 16'd0;
    logic [31:0] ref_rf [32] = '{default: 32'd0};
    logic [31:0] rf     [32] = '{default: 32'd0};
    logic [5:0]  functs [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00,
                                 6'h02, 6'h03, 6'h2B, 6'h2A};

    // Datapath model: ALU interpreting Op, register file written at end of WB
    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << sh;
            4'd5: return a >> sh;
            4'd6: return $signed(a) >>> sh;
            4'd7: return {31'd0, $signed(a) > $signed(b)};
            4'd8: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    // Register file driven purely by the sequencer's outputs
    always @(posedge Clk) begin
        if (WE) rf[WR] <= MuxCtrl ? alu(Op, rf[RR1], rf[RR2], ShiftCount) : WD;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] li(input logic [4:0] rt, input logic [15:0] imm);
        return {6'h0F, 5'd0, rt, imm};
    endfunction

    function automatic exp_t mk(input logic legal, input logic [4:0] rr1, input logic [4:0] rr2,
                                input logic [4:0] wr, input logic [3:0] op, input logic [4:0] sh,
                                input logic mux, input logic [31:0] wd, input logic [31:0] result);
        exp_t e;
        e.legal = legal; e.rr1 = rr1; e.rr2 = rr2; e.wr = wr; e.op = op;
        e.sh = sh; e.mux = mux; e.wd = wd; e.result = result;
        return e;
    endfunction

    // Instruction-level reference: what the instruction means and where it goes
    function automatic exp_t ref_model(input logic [31:0] ins);
        exp_t        e;
        logic [5:0]  opc   = ins[31:26];
        logic [4:0]  rs    = ins[25:21];
        logic [4:0]  rt    = ins[20:16];
        logic [4:0]  rd    = ins[15:11];
        logic [4:0]  shamt = ins[10:6];
        logic [5:0]  fn    = ins[5:0];
        logic [31:0] a     = ref_rf[rs];
        logic [31:0] b     = ref_rf[rt];
        logic [31:0] sext  = {{16{ins[15]}}, ins[15:0]};
        int          k     = -1;
        e = mk(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) if (functs[i] == fn) k = i;
        if (opc == 6'h0F) begin
            e = mk(1'b1, rt, rt, rt, 4'd0, 5'd0, 1'b0, sext, sext);
        end else if (opc == 6'h00 && k >= 0) begin
            logic shift = (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03);
            logic [31:0] res;
            case (fn)
                6'h20:   res = a + b;
                6'h22:   res = a - b;
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h00:   res = b << shamt;
                6'h02:   res = b >> shamt;
                6'h03:   res = $signed(b) >>> shamt;
                6'h2B:   res = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
                default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            e = mk(1'b1, shift ? rt : rs, rt, rd, 4'(k), shamt, 1'b1, 32'd0, res);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  InstrReady, 1);
        chk({tag, "_we"},     WE, 0);
        chk({tag, "_done"},   Done, 0);
        chk({tag, "_illegal"}, Illegal, 0);
        chk({tag, "_rr1"},    RR1, 0);
        chk({tag, "_rr2"},    RR2, 0);
        chk({tag, "_wr"},     WR, 0);
        chk({tag, "_op"},     Op, 0);
        chk({tag, "_shift"},  ShiftCount, 0);
        chk({tag, "_wd"},     WD, 0);
        chk({tag, "_mux"},    MuxCtrl, 0);
        chk({tag, "_retire"}, RetireCount, 0);
    endtask

    // Issue one instruction from an IDLE cycle and check its whole lifetime.
    // Called #1 after a rising edge; returns #1 after a rising edge in IDLE.
    task automatic run_instr(input logic [31:0] ins, input exp_t e);
        logic [31:0] junk;
        chk("ready_before_accept", InstrReady, 1);
        InstrValid = 1'b1;
        Instr      = ins;
        @(posedge Clk); #1;
        junk = $urandom;
        chk("illegal_c1", Illegal, !e.legal);
        chk("ready_c1", InstrReady, 0);
        chk("we_c1", WE, 0);
        chk("done_c1", Done, 0);
        if (!e.legal) begin
            InstrValid = 1'b0;
            Instr      = junk;
            @(posedge Clk); #1;
            chk("ready_c2_after_illegal", InstrReady, 1);
            chk("illegal_c2", Illegal, 0);
            chk("we_c2_after_illegal", WE, 0);
            chk("retire_unchanged", RetireCount, exp_retire);
        end else begin
            chk("rr1", RR1, e.rr1);
            chk("rr2", RR2, e.rr2);
            chk("wr", WR, e.wr);
            chk("op", Op, e.op);
            chk("shift", ShiftCount, e.sh);
            chk("mux", MuxCtrl, e.mux);
            if (!e.mux) chk("wd", WD, e.wd);
            // Busy-time offers must be ignored
            InstrValid = 1'b1;
            Instr      = junk;
            @(posedge Clk); #1;
            chk("we_c2", WE, 0);
            chk("done_c2", Done, 0);
            chk("ready_c2", InstrReady, 0);
            @(posedge Clk); #1;
            InstrValid = 1'b0;
            chk("we_c3", WE, 1);
            chk("done_c3", Done, 1);
            chk("wr_held_c3", WR, e.wr);
            chk("op_held_c3", Op, e.op);
            @(posedge Clk); #1;
            chk("we_c4", WE, 0);
            chk("done_c4", Done, 0);
            chk("ready_c4", InstrReady, 1);
            exp_retire = exp_retire + 16'd1;
            chk("retire_count", RetireCount, exp_retire);
            chk("rf_write", rf[e.wr], e.result);
            ref_rf[e.wr] = e.result;
        end
    endtask

    task automatic back_to_back();
        logic [31:0] b2b [4];
        int          acc [$];
        int          done_cnt = 0;
        int          idx = 0;
        bit          will_acc;
        for (int i = 0; i < 4; i++) b2b[i] = li(5'(10 + i), 16'($urandom));
        InstrValid = 1'b1;
        Instr      = b2b[0];
        for (int c = 0; c < 24; c++) begin
            will_acc = InstrReady && InstrValid;
            @(posedge Clk); #1;
            if (Done) done_cnt++;
            if (will_acc) begin
                acc.push_back(c);
                idx++;
                if (idx < 4) Instr = b2b[idx];
                else InstrValid = 1'b0;
            end
        end
        InstrValid = 1'b0;
        chk("b2b_accept_count", acc.size(), 4);
        chk("b2b_done_count", done_cnt, 4);
        if (acc.size() > 0) chk("b2b_first_accept", acc[0], 0);
        for (int i = 1; i < acc.size(); i++) chk("b2b_accept_gap", acc[i] - acc[i-1], 4);
        for (int i = 0; i < 4; i++) begin
            exp_t e = ref_model(b2b[i]);
            chk("b2b_rf", rf[10 + i], e.result);
            ref_rf[10 + i] = e.result;
        end
        exp_retire = exp_retire + 16'd4;
        chk("b2b_retire", RetireCount, exp_retire);
    endtask

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{li(5'd0, 16'hFFFE),              mk(1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'hFFFFFFFE)};
        tbl[1] = '{li(5'd1, 16'd1200),              mk(1, 1, 1, 1, 0, 0, 0, 32'h000004B0, 32'h000004B0)};
        tbl[2] = '{rtype(0, 1, 2, 0, 6'h20),        mk(1, 0, 1, 2, 0, 0, 1, 32'h0, 32'h000004AE)};
        tbl[3] = '{li(5'd3, 16'hF830),              mk(1, 3, 3, 3, 0, 0, 0, 32'hFFFFF830, 32'hFFFFF830)};
        tbl[4] = '{rtype(3, 0, 5, 0, 6'h22),        mk(1, 3, 0, 5, 1, 0, 1, 32'h0, 32'hFFFFF832)};
        tbl[5] = '{li(5'd4, 16'hFFFE),              mk(1, 4, 4, 4, 0, 0, 0, 32'hFFFFFFFE, 32'hFFFFFFFE)};
        tbl[6] = '{rtype(0, 4, 6, 2, 6'h00),        mk(1, 4, 4, 6, 4, 2, 1, 32'h0, 32'hFFFFFFF8)};
        tbl[7] = '{rtype(0, 4, 7, 1, 6'h03),        mk(1, 4, 4, 7, 6, 1, 1, 32'h0, 32'hFFFFFFFF)};
        tbl[8] = '{32'hFC000000,                    mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0)};
        tbl[9] = '{rtype(1, 2, 3, 0, 6'h3F),        mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0)};

        Rst        = 1'b1;
        InstrValid = 1'b0;
        Instr      = 32'd0;
        #2;
        chk_reset_vals("reset");
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) run_instr(tbl[i].instr, tbl[i].e);

        // Reset in EXEC of an add targeting r9 must abort the write
        run_instr(li(5'd9, 16'd55), ref_model(li(5'd9, 16'd55)));
        InstrValid = 1'b1;
        Instr      = rtype(1, 2, 9, 0, 6'h20);
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk_reset_vals("midop_reset");
        @(posedge Clk); #1;
        chk("midop_we_held_low", WE, 0);
        Rst = 1'b0;
        exp_retire = 16'd0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("midop_r9_kept", rf[9], 32'd55);
        run_instr(li(5'd9, 16'd77), ref_model(li(5'd9, 16'd77)));

        // InstrValid held high across four instructions
        back_to_back();

        // Randomized instructions against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] rnd = $urandom;
            int          r   = $urandom_range(0, 9);
            logic [31:0] ins;
            if (r < 6)      ins = {6'h00, rnd[25:6], functs[$urandom_range(0, 8)]};
            else if (r < 8) ins = {6'h0F, rnd[25:0]};
            else            ins = rnd;
            run_instr(ins, ref_model(ins));
        end

        // Counter wrap: preload near the top, then retire across the boundary
        force dut.retire_q = 16'hFFFE;
        @(posedge Clk); #1;
        release dut.retire_q;
        exp_retire = 16'hFFFE;
        @(posedge Clk); #1;
        run_instr(li(5'd20, 16'd1), ref_model(li(5'd20, 16'd1)));
        run_instr(li(5'd21, 16'd2), ref_model(li(5'd21, 16'd2)));
        chk("retire_wrapped_to_zero", RetireCount, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that sits directly upstream of the register file / ALU / write-back mux datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it, and drives the register-file read/write addresses, write enable, ALU op code, shift count, write-back mux select and immediate write data. It also reports completion, illegal encodings and a retired-instruction count.

## Interface
- No parameters; all widths fixed to match the datapath (5-bit register address, 4-bit ALU op, 32-bit data).
- Clk  in  1  system clock, rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- InstrValid  in  1  instruction present on Instr.
- Instr  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- InstrReady  out  1  sequencer can accept an instruction.
- RR1, RR2  out  5  register-file read addresses.
- WR  out  5  register-file write address.
- WE  out  1  register-file write enable.
- WD  out  32  immediate write data, routed to the mux input selected by MuxCtrl=0.
- MuxCtrl  out  1  0 = write WD, 1 = write ALU result.
- Op  out  4  ALU op code.
- ShiftCount  out  5  ALU shift amount.
- Done  out  1  one-cycle pulse per retired instruction.
- Illegal  out  1  one-cycle pulse per rejected instruction.
- RetireCount  out  16  retired-instruction counter.

## Operation
- States: IDLE, DECODE, EXEC, WB.
- IDLE: InstrReady=1. On a rising edge with InstrValid=1, latch Instr and go to DECODE. Otherwise stay in IDLE.
- DECODE: InstrReady=0. Decode the latched word and register all datapath outputs.
  - Legal encoding: go to EXEC.
  - Illegal encoding: pulse Illegal, go to IDLE, keep WE=0.
- EXEC: outputs held, WE=0. This cycle lets the register-file read and ALU settle. Go to WB.
- WB: WE=1 and Done=1 for exactly this cycle; the register file writes on the edge that ends WB. RetireCount increments on that edge and wraps from 0xFFFF to 0x0000. Go to IDLE.
- R-type instructions (opcode 0x00). Op is set from funct; MuxCtrl=1; WR=rd; RR1=rs; RR2=rt; ShiftCount=shamt.
  - funct 0x20 add: Op 0.
  - funct 0x22 sub: Op 1.
  - funct 0x24 and: Op 2.
  - funct 0x25 or: Op 3.
  - funct 0x00 sll: Op 4.
  - funct 0x02 srl: Op 5.
  - funct 0x03 sra: Op 6.
  - funct 0x2B sgt: Op 7.
  - funct 0x2A slt: Op 8.
  - For shift ops (4, 5, 6): RR1=rt and RR2=rt, so the ALU A input is the shifted operand.
- Load-immediate (opcode 0x0F): MuxCtrl=0; WD=sign-extended imm; WR=rt; RR1=RR2=rt; Op=0; ShiftCount=0.
- Any other opcode, or any other funct under opcode 0x00, is illegal.
- Writes to address 0 are performed normally; register 0 is not hardwired.
- RR1, RR2, WR, WD, MuxCtrl, Op and ShiftCount hold their DECODE values through EXEC, WB and the following IDLE cycles until the next DECODE.

## Timing
- Reset values, forced immediately on Rst assertion:
  - State IDLE; InstrReady=1.
  - WE, Done, Illegal = 0.
  - RR1, RR2, WR, Op, ShiftCount = 0; WD=0; MuxCtrl=0; RetireCount=0.
- Reset mid-instruction aborts it with no write. WE drops asynchronously, with no glitch pulse.
- Latency: accept edge = cycle 0; DECODE = cycle 1; EXEC = cycle 2; WB = cycle 3, with the write at the end of cycle 3.
- Throughput: one instruction per 4 cycles.
- Illegal instruction: Illegal is high in cycle 1; InstrReady is high again in cycle 2.
- InstrValid held high continuously: the next instruction is accepted on the first edge after returning to IDLE, i.e. the edge ending cycle 4. No instruction is dropped or double-accepted.
- InstrValid seen while InstrReady=0 is ignored, and the Instr value is not sampled.
- All outputs are registered; no combinational path from Instr or InstrValid to any output.

## Test plan
- Reset, then add: load-immediate -2 into r0 and 1200 into r1, then add r2=r0+r1. Required: r2=1198; Op=0 and MuxCtrl=1 during the add; Done pulses 3 cycles after each accept; RetireCount=3.
- Sub: with r0=-2 and r3=-2000, issue sub r5=r3-r0. Required: r5=-1998; Op=1; WE high only in the WB cycle.
- Shift: with r4=-2, issue sll r6,r4,shamt 2. Required: RR1=RR2=4, Op=4, ShiftCount=2, r6=-8. Then sra r7,r4,1: required Op=6, r7=-1.
- Illegal: opcode 0x3F, then R-type funct 0x3F. Required: Illegal pulses in cycle 1 each time; WE never high; RetireCount unchanged; InstrReady high in cycle 2.
- Reset mid-op: assert Rst in EXEC of an add targeting r9 (r9 preset to 55). Required: r9 stays 55; all outputs at reset values immediately; a fresh instruction is accepted after Rst drops.
- Back-to-back and wrap: hold InstrValid high for 4 instructions. Required: accepts exactly 4 cycles apart and 4 Done pulses. Separately, 65536 load-immediates make RetireCount wrap to 0.
